// File: rtl/output_ctrl_pkg.sv
// ============================================================================
//  Module      : output_ctrl_pkg
//  Description : Shared phase and virtual-channel constants for the router
//                port controllers (input and output side).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package output_ctrl_pkg;

    // Link phase encoding; the output polarity bit carries this value.
    localparam logic POL_EVEN = 1'b0;
    localparam logic POL_ODD  = 1'b1;

    // VC buffer indices; the link-side VC index equals the polarity bit.
    localparam int VC_EVEN = 0;
    localparam int VC_ODD  = 1;
    localparam int NUM_VC  = 2;

endpackage : output_ctrl_pkg

`default_nettype wire

// File: rtl/output_ctrl_rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. One-hot combinational grant, search
//                starts at the registered pointer, pointer moves to the
//                slot after the winner whenever a grant is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import output_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] idx;
    logic          found;
    int            k;

    // First active request at or after the pointer, wrapping around.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        win_idx = '0;
        idx     = '0;
        k       = 0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                k = int'(ptr) + i;
                if (k >= N) begin
                    k = k - N;
                end
                idx = PW'(k);
                if (!found && req[idx]) begin
                    found   = 1'b1;
                    win_idx = idx;
                end
            end
        end
        if (found) begin
            grant[win_idx] = 1'b1;
        end
    end

    // Pointer advances past the winner; it holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/output_ctrl_vc_buffer.sv
// ============================================================================
//  Module      : vc_buffer
//  Description : Small circular flit buffer for one virtual channel.
//                Head is visible combinationally on dout; push into a full
//                buffer and pop from an empty one are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_buffer
    import output_ctrl_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    // Storage array; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule : vc_buffer

`default_nettype wire

// File: rtl/output_ctrl.sv
// ============================================================================
//  Module      : output_ctrl
//  Description : Router output-port controller. Arbitrates input-controller
//                requests into the crossbar-side VC buffer and drives the
//                link from the link-side VC buffer; the two swap roles every
//                cycle as polarity toggles.
//                Optional macro OUTPUT_CTRL_PERF_EN adds saturating
//                flit_cnt / stall_cnt performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_ctrl
    import output_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_IN       = 4,
    parameter int BUFFER_DEPTH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN-1:0]            sig_req_channel,
    input  logic [NUM_IN*DATA_WIDTH-1:0] inner_dataI,
    output logic [NUM_IN-1:0]            sig_channel_clean,
    input  logic                         receiveO,
    output logic                         sendO,
    output logic [DATA_WIDTH-1:0]        dataO,
    output logic                         polarity
`ifdef OUTPUT_CTRL_PERF_EN
    ,
    output logic [15:0]                  flit_cnt,
    output logic [15:0]                  stall_cnt
`endif
);

    logic [NUM_IN-1:0]     grant;
    logic [NUM_VC-1:0]     vc_full;
    logic [NUM_VC-1:0]     vc_push;
    logic [NUM_VC-1:0]     vc_pop;
    logic [DATA_WIDTH-1:0] vc_dout [NUM_VC];
    logic [DATA_WIDTH-1:0] xbar_data;
    logic                  link_idx;
    logic                  xbar_idx;
    logic                  link_full;
    logic                  xbar_full;

    // Link-side VC index equals the phase bit; crossbar side is the other.
    assign link_idx  = polarity;
    assign xbar_idx  = ~polarity;
    assign link_full = vc_full[link_idx];
    assign xbar_full = vc_full[xbar_idx];

    // Phase alternates every cycle; there is no idle phase.
    always_ff @(posedge clk) begin
        if (rst) polarity <= POL_EVEN;
        else     polarity <= ~polarity;
    end

    // Reset suppresses grants in the same cycle; a full crossbar VC stalls them.
    rr_arbiter #(
        .N (NUM_IN)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (sig_req_channel),
        .en    (!rst && !xbar_full),
        .grant (grant)
    );

    assign sig_channel_clean = grant;

    // One-hot OR-mux of the granted input's flit.
    always_comb begin
        xbar_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                xbar_data = xbar_data | inner_dataI[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Link drive is zero-latency from the link-side head; forced idle in reset.
    assign sendO = !rst && link_full && receiveO;
    assign dataO = sendO ? vc_dout[link_idx] : '0;

    // Push targets the crossbar VC, pop the link VC; they never coincide.
    always_comb begin
        vc_push           = '0;
        vc_pop            = '0;
        vc_push[xbar_idx] = |grant;
        vc_pop[link_idx]  = sendO;
    end

    generate
        for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
            vc_buffer #(
                .WIDTH (DATA_WIDTH),
                .DEPTH (BUFFER_DEPTH)
            ) u_buf (
                .clk  (clk),
                .rst  (rst),
                .push (vc_push[v]),
                .din  (xbar_data),
                .pop  (vc_pop[v]),
                .dout (vc_dout[v]),
                .full (vc_full[v])
            );
        end
    endgenerate

`ifdef OUTPUT_CTRL_PERF_EN
    logic [15:0] flit_cnt_q;
    logic [15:0] stall_cnt_q;

    // Saturating counts of sent flits and link-side backpressure cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            flit_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (sendO && flit_cnt_q != 16'hFFFF) begin
                flit_cnt_q <= flit_cnt_q + 16'd1;
            end
            if (link_full && !receiveO && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign flit_cnt  = flit_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    // Performance counters not built; datapath is identical.
`endif

endmodule : output_ctrl

`default_nettype wire
